vsng: RTL and testbench
=======================

# vsng

Variable-precision stochastic number generator: converts a W-bit unsigned binary value into a unipolar stochastic bitstream of length 2^k. It is the transmit-side counterpart of the variable-shift binary counter that converts streams back to binary. The comparison source is a bit-reversed (van der Corput) counter, so every prefix of length 2^j, j ≤ k, is an exact j-bit encoding. This is what allows downstream logic to terminate early and keep a valid lower-precision result.

## Interface
- W, 8: value width; also the maximum log2 stream length.
- LW, $clog2(W+1): width of `len_log`.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a new stream; accepted when `start && ready`.
- x_in  in  W  binary value, sampled on acceptance.
- len_log  in  LW  log2 of stream length, sampled on acceptance; values > W clamp to W.
- halt  in  1  early-termination request; acts only in RUN.
- ready  out  1  high in IDLE.
- Z  out  1  stream bit; meaningful only while `z_valid`.
- z_valid  out  1  stream bit presented.
- z_ready  in  1  consumer accepts the bit; a transfer occurs on `z_valid && z_ready`.
- last  out  1  the presented bit is the final bit of the stream.
- count  out  W+1  number of bits transferred in the current or most recent stream.

## Operation
- States: IDLE and RUN. Registers: `x_reg[W-1:0]`, `k_reg[LW-1:0]`, `cnt[W-1:0]`, `count[W:0]`.
- IDLE:
  - `ready=1`, `z_valid=0`, `Z=0`, `last=0`.
  - On `start`: x_reg←x_in, k_reg←min(len_log,W), cnt←0, count←0, state←RUN.
- RUN:
  - r = bit-reverse of cnt over W bits.
  - Z = (r < x_reg), combinational from registers.
  - `z_valid = !halt`.
  - `last = !halt && (cnt == 2^k_reg − 1)`.
- On transfer:
  - cnt←cnt+1 and count←count+1.
  - If `last`, state←IDLE.
- With `z_ready=0`, cnt, Z and last hold unchanged (stall).
- Halt in RUN:
  - The bit presented in that cycle is withdrawn (`z_valid=0`), so no transfer occurs.
  - State←IDLE at the next edge.
  - count keeps the number already transferred.
- Halt in IDLE is ignored.
- Start in RUN is ignored (`ready=0`).
- Exactness: after 2^j transfers (j ≤ k_reg), the number of ones equals ceil(x_reg / 2^(W−j)). Consequences:
  - x=0 gives all zeros.
  - x=2^W−1 with k=W gives 2^W−1 ones.
- k_reg=0 gives a single bit: Z = (x_reg != 0).
- cnt never wraps. The final transfer at cnt=2^W−1 returns the block to IDLE, and cnt is reloaded only on acceptance.
- count holds its value in IDLE until the next acceptance. Maximum count is 2^W.

## Timing
- Reset values:
  - State IDLE.
  - cnt=0, count=0, x_reg=0, k_reg=0.
  - Outputs: ready=1, z_valid=0, Z=0, last=0, count=0.
- Reset asserted mid-RUN returns to IDLE at that edge. No further bits are presented.
- Acceptance edge at cycle t: the first bit is presented in cycle t+1.
- With `z_ready` held high, one bit per cycle. The stream occupies cycles t+1 … t+2^k.
- ready rises in the cycle after the `last` transfer, or after the halt cycle. Back-to-back streams therefore have one idle cycle between them.
- No combinational path from `x_in`/`len_log` to outputs. Combinational paths exist from `halt` to `z_valid`/`last` only.

## Configuration
- VSNG_ONES_CNT_EN defined:
  - Adds output port `ones[W:0]`: the number of transfers with Z=1 in the current or most recent stream.
  - Cleared on acceptance and on reset; held in IDLE.
- VSNG_ONES_CNT_EN undefined: the `ones` port and its register do not exist. All other behaviour is identical.

## Test plan
- W=8, x_in=96, len_log=3, z_ready=1 → Z sequence 1,0,1,0,1,0,0,0; last on the 8th bit; count=8; ones=3; ready=1 one cycle later.
- x_in=200, len_log=8 → 256 transfers, 200 ones. Check after the 16-bit prefix: 13 ones (ceil(200/16)).
- x_in=96, len_log=3, z_ready low for 3 cycles after the 2nd bit → Z and cnt frozen; same sequence as scenario 1; completion delayed by 3 cycles.
- Halt asserted in the cycle presenting the 6th bit → z_valid=0 that cycle; IDLE next edge; count=5; ones=3.
- rst_n low mid-stream, then start with x_in=0, len_log=9 → clean restart; k clamped to 8; 256 zeros; count=256.
- start held high through a stream, halt pulsed in IDLE → exactly one stream per acceptance, with an idle cycle between streams; halt in IDLE has no effect.

Source files
------------

// File: rtl/vsng.sv
// vsng - variable-precision stochastic number generator.
//
// Converts a W-bit unsigned value into a unipolar stochastic bitstream of
// length 2^k. Each bit compares the value against a bit-reversed
// (van der Corput) counter. Every power-of-two prefix of the stream is
// therefore an exact lower-precision encoding, so a consumer may stop
// early and still hold a valid result.
//
// Optional feature macro: VSNG_ONES_CNT_EN adds the `ones` output, which
// counts the transferred 1-bits of the current or most recent stream.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   request a new stream (accepted when start && ready)
//   x_in     in   W-bit value, sampled on acceptance
//   len_log  in   log2 of stream length, sampled on acceptance (clamped to W)
//   halt     in   early termination; acts only while a stream runs
//   ready    out  idle, able to accept start
//   Z        out  stream bit, meaningful while z_valid
//   z_valid  out  stream bit presented
//   z_ready  in   consumer accepts the presented bit
//   last     out  presented bit is the final bit of the stream
//   count    out  bits transferred in the current or most recent stream
//   ones     out  (VSNG_ONES_CNT_EN only) 1-bits transferred in that stream
module vsng #(
  parameter int W  = 8,
  parameter int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  x_in,
  input  logic [LW-1:0] len_log,
  input  logic          halt,
  output logic          ready,
  output logic          Z,
  output logic          z_valid,
  input  logic          z_ready,
  output logic          last,
`ifdef VSNG_ONES_CNT_EN
  output logic [W:0]    ones,
`endif
  output logic [W:0]    count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    x_reg;
  logic [LW-1:0]   k_reg;
  logic [W-1:0]    cnt;
  logic [W-1:0]    cnt_rev;
  logic [W:0]      end_cnt;
  logic            cnt_at_end;
  logic            xfer;
  logic            accept;

  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l > LW'(W)) return LW'(W);
    return l;
  endfunction

  assign cnt_rev    = bit_rev(cnt);
  // Index of the final bit, 2^k - 1; one bit wider so k = W still fits.
  assign end_cnt    = ((W+1)'(1) << k_reg) - (W+1)'(1);
  assign cnt_at_end = ({1'b0, cnt} == end_cnt);

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    Z         = 1'b0;
    z_valid   = 1'b0;
    last      = 1'b0;
    xfer      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = start;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        Z       = (cnt_rev < x_reg);
        // Halt withdraws the presented bit in the same cycle.
        z_valid = !halt;
        last    = !halt && cnt_at_end;
        xfer    = z_valid && z_ready;
        if (halt)              state_nxt = IDLE;
        else if (xfer && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      x_reg <= '0;
      k_reg <= '0;
      cnt   <= '0;
      count <= '0;
`ifdef VSNG_ONES_CNT_EN
      ones  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_reg <= x_in;
        k_reg <= clamp_len(len_log);
        cnt   <= '0;
        count <= '0;
`ifdef VSNG_ONES_CNT_EN
        ones  <= '0;
`endif
      end else if (xfer) begin
        // Hold cnt on the final bit so it never wraps at k = W.
        if (!last) cnt <= cnt + W'(1);
        count <= count + (W+1)'(1);
`ifdef VSNG_ONES_CNT_EN
        ones  <= ones + {{W{1'b0}}, Z};
`endif
      end
    end
  end

endmodule

// File: tb/tb_vsng.sv
module tb_vsng;

  localparam int W  = 8;
  localparam int LW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  x_in;
  logic [LW-1:0] len_log;
  logic          halt;
  logic          ready;
  logic          Z;
  logic          z_valid;
  logic          z_ready;
  logic          last;
  logic [W:0]    count;
`ifdef VSNG_ONES_CNT_EN
  logic [W:0]    ones;
`endif

  int nchk  = 0;
  int nfail = 0;

  // Expected Z for x=96, k=3: bit i of seq96 is the (i+1)-th stream bit.
  logic [7:0] seq96 = 8'b0001_0101;

  vsng #(.W(W), .LW(LW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x_in    (x_in),
    .len_log (len_log),
    .halt    (halt),
    .ready   (ready),
    .Z       (Z),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .last    (last),
`ifdef VSNG_ONES_CNT_EN
    .ones    (ones),
`endif
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_stream(input logic [W-1:0] x, input logic [LW-1:0] l);
    start   = 1'b1;
    x_in    = x;
    len_log = l;
    tick();
    start   = 1'b0;
    #1;
  endtask

  // Consume the stream with z_ready high; bounded by max_cyc.
  task automatic run_count(input int max_cyc, output int n, output int n1,
                           output int n1_16, output int last_at);
    bit done = 0;
    n = 0; n1 = 0; n1_16 = -1; last_at = -1;
    for (int c = 0; c < max_cyc && !done; c++) begin
      if (z_valid && z_ready) begin
        n++;
        n1 += int'(Z);
        if (n == 16) n1_16 = n1;
        if (last) begin
          last_at = n;
          done = 1;
        end
      end
      tick();
    end
  endtask

  initial begin
    int n, n1, n1_16, last_at, o;

    rst_n = 1'b0; start = 1'b0; x_in = '0; len_log = '0; halt = 1'b0; z_ready = 1'b1;
    tick(); tick();
    chk("rst_ready", 32'(ready), 1);
    chk("rst_zvalid", 32'(z_valid), 0);
    chk("rst_Z", 32'(Z), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_count", 32'(count), 0);
`ifdef VSNG_ONES_CNT_EN
    chk("rst_ones", 32'(ones), 0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic stream x=96, k=3.
    start_stream(8'd96, 4'd3);
    chk("s1_ready_run", 32'(ready), 0);
    o = 0;
    for (int i = 0; i < 8; i++) begin
      chk("s1_zvalid", 32'(z_valid), 1);
      chk("s1_Z", 32'(Z), 32'(seq96[i]));
      chk("s1_last", 32'(last), (i == 7) ? 1 : 0);
      o += int'(Z);
      tick();
    end
    chk("s1_ready_after", 32'(ready), 1);
    chk("s1_count", 32'(count), 8);
    chk("s1_ones_obs", 32'(o), 3);
`ifdef VSNG_ONES_CNT_EN
    chk("s1_ones", 32'(ones), 3);
`endif
    tick();

    // Stall after the 2nd bit.
    start_stream(8'd96, 4'd3);
    chk("s3_Z0", 32'(Z), 32'(seq96[0]));
    tick();
    z_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("s3_stall_Z", 32'(Z), 32'(seq96[1]));
      chk("s3_stall_last", 32'(last), 0);
      chk("s3_stall_count", 32'(count), 1);
      chk("s3_stall_zvalid", 32'(z_valid), 1);
      tick();
    end
    z_ready = 1'b1;
    #1;
    for (int i = 1; i < 8; i++) begin
      chk("s3_Z", 32'(Z), 32'(seq96[i]));
      chk("s3_last", 32'(last), (i == 7) ? 1 : 0);
      tick();
    end
    chk("s3_ready", 32'(ready), 1);
    chk("s3_count", 32'(count), 8);

    // Halt on the 6th bit.
    start_stream(8'd96, 4'd3);
    o = 0;
    for (int i = 0; i < 5; i++) begin
      chk("s4_Z", 32'(Z), 32'(seq96[i]));
      o += int'(Z);
      tick();
    end
    halt = 1'b1;
    #1;
    chk("s4_halt_zvalid", 32'(z_valid), 0);
    chk("s4_halt_last", 32'(last), 0);
    tick();
    halt = 1'b0;
    #1;
    chk("s4_ready", 32'(ready), 1);
    chk("s4_zvalid_idle", 32'(z_valid), 0);
    chk("s4_count", 32'(count), 5);
    chk("s4_ones_obs", 32'(o), 3);
`ifdef VSNG_ONES_CNT_EN
    chk("s4_ones", 32'(ones), 3);
`endif

    // Full-length stream x=200, k=8.
    start_stream(8'd200, 4'd8);
    run_count(300, n, n1, n1_16, last_at);
    chk("s2_n", 32'(n), 256);
    chk("s2_ones16", 32'(n1_16), 13);
    chk("s2_ones", 32'(n1), 200);
    chk("s2_last_at", 32'(last_at), 256);
    chk("s2_count", 32'(count), 256);
    chk("s2_ready", 32'(ready), 1);
`ifdef VSNG_ONES_CNT_EN
    chk("s2_ones_port", 32'(ones), 200);
`endif

    // Reset mid-stream, then x=0 with len_log clamped from 9 to 8.
    start_stream(8'd96, 4'd3);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("s5_rst_ready", 32'(ready), 1);
    chk("s5_rst_zvalid", 32'(z_valid), 0);
    chk("s5_rst_count", 32'(count), 0);
    rst_n = 1'b1;
    start_stream(8'd0, 4'd9);
    run_count(300, n, n1, n1_16, last_at);
    chk("s5_n", 32'(n), 256);
    chk("s5_ones", 32'(n1), 0);
    chk("s5_last_at", 32'(last_at), 256);
    chk("s5_count", 32'(count), 256);

    // start held high; halt pulsed in IDLE.
    for (int c = 0; c < 18; c++) begin
      start   = 1'b1;
      x_in    = 8'd96;
      len_log = 4'd3;
      halt    = (c == 9);
      #1;
      chk("s6_ready", 32'(ready), (c % 9 == 0) ? 1 : 0);
      chk("s6_zvalid", 32'(z_valid), (c % 9 == 0) ? 0 : 1);
      if (c % 9 != 0) chk("s6_Z", 32'(Z), 32'(seq96[(c % 9) - 1]));
      tick();
    end
    start = 1'b0;
    halt  = 1'b0;
    #1;
    chk("s6_end_ready", 32'(ready), 1);
    chk("s6_end_count", 32'(count), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
